// File: rtl/alu_ctrl.sv
// alu_ctrl: launches one ALU operation at a time, captures the result LAT edges later.
// Optional ALU_CTRL_ACC_EN adds req_acc and an accumulator that can replace req_a.
module alu_ctrl #(
    parameter int n   = 8,
    parameter int LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [n-1:0] req_a,
    input  logic [n-1:0] req_b,
`ifdef ALU_CTRL_ACC_EN
    input  logic         req_acc,
`endif
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output logic [1:0]   alu_func,
    input  logic [n-1:0] alu_result,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT4 = 4'(LAT);

    state_t       state;
    logic [3:0]   cnt;
    logic [n-1:0] launch_a;
    logic         capture;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign capture   = (state == EXEC) && (cnt == 4'd1);

`ifdef ALU_CTRL_ACC_EN
    logic [n-1:0] acc;

    assign launch_a = req_acc ? acc : req_a;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (capture) begin
            acc <= alu_result;
        end
    end
`else
    assign launch_a = req_a;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_func  <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        alu_a    <= launch_a;
                        alu_b    <= req_b;
                        alu_func <= req_op;
                        cnt      <= LAT4;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        rsp_data  <= alu_result;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: two controllers (LAT=1 and LAT=3) against a small ALU model,
// checked with directed and random operations; define ALU_CTRL_ACC_EN for the accumulator path.
module tb_alu_ctrl;

`ifdef ALU_CTRL_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       req_valid  [2];
    logic       req_ready  [2];
    logic [1:0] req_op     [2];
    logic [7:0] req_a      [2];
    logic [7:0] req_b      [2];
`ifdef ALU_CTRL_ACC_EN
    logic       req_acc    [2];
`endif
    logic [7:0] alu_a      [2];
    logic [7:0] alu_b      [2];
    logic [1:0] alu_func   [2];
    logic [7:0] alu_result [2];
    logic       rsp_valid  [2];
    logic       rsp_ready  [2];
    logic [7:0] rsp_data   [2];
    logic       busy       [2];

    int total = 0;
    int passed = 0;
    int fails = 0;
    logic [7:0] acc_ref [2];

    // ALU environment: Q1.7 fractional multiply keeps the integer part.
    function automatic logic [7:0] alu_env(logic [1:0] f, logic [7:0] a, logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        case (f)
            2'b10:   return a + b;
            2'b11:   return 8'(p >> 7);
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [7:0] ref_result(logic [1:0] op, logic [7:0] a, logic [7:0] b);
        int x;
        if (op == 2'b10) x = (int'(a) + int'(b)) % 256;
        else if (op == 2'b11) x = ((int'(a) * int'(b)) / 128) % 256;
        else x = int'(a ^ b);
        return 8'(x);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_ctrl #(.n(8), .LAT(g == 0 ? 1 : 3)) dut (
            .clk        (clk),
            .reset      (reset),
            .req_valid  (req_valid[g]),
            .req_ready  (req_ready[g]),
            .req_op     (req_op[g]),
            .req_a      (req_a[g]),
            .req_b      (req_b[g]),
`ifdef ALU_CTRL_ACC_EN
            .req_acc    (req_acc[g]),
`endif
            .alu_a      (alu_a[g]),
            .alu_b      (alu_b[g]),
            .alu_func   (alu_func[g]),
            .alu_result (alu_result[g]),
            .rsp_valid  (rsp_valid[g]),
            .rsp_ready  (rsp_ready[g]),
            .rsp_data   (rsp_data[g]),
            .busy       (busy[g])
        );
        assign alu_result[g] = alu_env(alu_func[g], alu_a[g], alu_b[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(int k, logic [1:0] op, logic [7:0] a, logic [7:0] b,
                          logic use_acc, int hold, logic noise);
        logic [7:0] ea;
        logic [7:0] exp;
        int lat;
        lat = (k == 0) ? 1 : 3;
        ea = (use_acc && ACC_EN) ? acc_ref[k] : a;
        exp = ref_result(op, ea, b);
        chk("idle_ready", req_ready[k], 1);
        req_valid[k] = 1'b1;
        req_op[k] = op;
        req_a[k] = a;
        req_b[k] = b;
`ifdef ALU_CTRL_ACC_EN
        req_acc[k] = use_acc;
`endif
        step();
        // Requests offered while busy must be ignored.
        req_valid[k] = noise;
        if (noise) begin
            req_op[k] = 2'($urandom);
            req_a[k] = 8'($urandom);
            req_b[k] = 8'($urandom);
        end
        chk("launch_a", alu_a[k], ea);
        chk("launch_b", alu_b[k], b);
        chk("launch_func", alu_func[k], op);
        chk("launch_busy", busy[k], 1);
        chk("launch_ready", req_ready[k], 0);
        chk("launch_rsp_valid", rsp_valid[k], 0);
        for (int i = 1; i < lat; i++) begin
            step();
            chk("exec_rsp_valid", rsp_valid[k], 0);
            chk("exec_a_stable", alu_a[k], ea);
            chk("exec_b_stable", alu_b[k], b);
            chk("exec_func_stable", alu_func[k], op);
        end
        step();
        chk("cap_rsp_valid", rsp_valid[k], 1);
        chk("cap_rsp_data", rsp_data[k], exp);
        acc_ref[k] = exp;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_rsp_valid", rsp_valid[k], 1);
            chk("hold_rsp_data", rsp_data[k], exp);
            chk("hold_ready", req_ready[k], 0);
            chk("hold_a", alu_a[k], ea);
        end
        rsp_ready[k] = 1'b1;
        step();
        rsp_ready[k] = 1'b0;
        req_valid[k] = 1'b0;
        chk("hs_rsp_valid", rsp_valid[k], 0);
        chk("hs_ready", req_ready[k], 1);
        chk("hs_busy", busy[k], 0);
        chk("hs_a_kept", alu_a[k], ea);
    endtask

    initial begin
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_op[k] = 2'b00;
            req_a[k] = 8'h00;
            req_b[k] = 8'h00;
            rsp_ready[k] = 1'b0;
`ifdef ALU_CTRL_ACC_EN
            req_acc[k] = 1'b0;
`endif
            acc_ref[k] = 8'h00;
        end
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", req_ready[k], 1);
            chk("rst_busy", busy[k], 0);
            chk("rst_rsp_valid", rsp_valid[k], 0);
            chk("rst_rsp_data", rsp_data[k], 0);
            chk("rst_alu_a", alu_a[k], 0);
            chk("rst_alu_b", alu_b[k], 0);
            chk("rst_alu_func", alu_func[k], 0);
        end

        run_op(0, 2'b10, 8'h03, 8'h14, 1'b0, 0, 1'b0);
        run_op(0, 2'b11, 8'h60, 8'h05, 1'b0, 0, 1'b0);
        chk("mul_data_literal", rsp_data[0], 8'h03);
        run_op(1, 2'b10, 8'h03, 8'h14, 1'b0, 1, 1'b0);
        chk("lat3_data_literal", rsp_data[1], 8'h17);
        run_op(1, 2'b11, 8'h60, 8'h05, 1'b0, 5, 1'b1);
        run_op(1, 2'b10, 8'h20, 8'h22, 1'b0, 0, 1'b0);
        chk("second_req_data", rsp_data[1], 8'h42);

        run_op(0, 2'b10, 8'hff, 8'h01, 1'b0, 0, 1'b0);
        run_op(0, 2'b11, 8'hff, 8'hff, 1'b0, 0, 1'b0);
        run_op(1, 2'b00, 8'h5a, 8'h0f, 1'b0, 2, 1'b1);
        run_op(0, 2'b01, 8'h33, 8'hcc, 1'b0, 0, 1'b1);

`ifdef ALU_CTRL_ACC_EN
        run_op(0, 2'b10, 8'h03, 8'h14, 1'b0, 0, 1'b0);
        run_op(0, 2'b10, 8'haa, 8'h01, 1'b1, 0, 1'b0);
        chk("acc_data_literal", rsp_data[0], 8'h18);
`endif

        // Reset while the LAT=3 controller is mid-operation.
        req_valid[1] = 1'b1;
        req_op[1] = 2'b10;
        req_a[1] = 8'h11;
        req_b[1] = 8'h22;
        step();
        req_valid[1] = 1'b0;
        chk("pre_rst_busy", busy[1], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        acc_ref[0] = 8'h00;
        acc_ref[1] = 8'h00;
        chk("mid_rst_busy", busy[1], 0);
        chk("mid_rst_alu_a", alu_a[1], 0);
        chk("mid_rst_alu_b", alu_b[1], 0);
        chk("mid_rst_func", alu_func[1], 0);
        chk("mid_rst_rsp_valid", rsp_valid[1], 0);
        chk("mid_rst_rsp_data", rsp_data[1], 0);
        chk("mid_rst_rsp_data0", rsp_data[0], 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_rsp_valid", rsp_valid[1], 0);
            chk("post_rst_ready", req_ready[1], 1);
        end

        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), 8'($urandom),
                   1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: n, default 8, operand/result width in bits.
REQ-002 Parameter: LAT, default 1, ALU result latency in clock edges after operand launch; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request offered.
REQ-006 req_ready  output  1  controller accepts request this cycle.
REQ-007 req_op  input  2  ALU function code: 2'b10 ADD, 2'b11 MUL (fractional); other codes are forwarded unchanged.
REQ-008 req_a, req_b  input  n  operands.
REQ-009 alu_a, alu_b  output  n  registered operands driving the ALU a/b ports.
REQ-010 alu_func  output  2  registered function code driving ALU ALUFunc.
REQ-011 alu_result  input  n  ALU result port.
REQ-012 rsp_valid  output  1  captured result available.
REQ-013 rsp_ready  input  1  consumer takes result.
REQ-014 rsp_data  output  n  captured result.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-017 In IDLE, req_ready SHALL be 1; in EXEC and DONE, req_ready SHALL be 0.
REQ-018 On an edge with req_valid=1 and req_ready=1, the block SHALL register req_a/req_b/req_op into alu_a/alu_b/alu_func, load a 4-bit latency counter with LAT, and enter EXEC.
REQ-019 alu_a/alu_b/alu_func SHALL remain stable from launch until the block returns to IDLE.
REQ-020 In EXEC, the counter SHALL decrement each edge; on the edge where the counter equals 1, the block SHALL capture alu_result into rsp_data and enter DONE, so capture occurs exactly LAT edges after the launch edge.
REQ-021 In DONE, rsp_valid SHALL be 1 and rsp_data SHALL be held stable until rsp_valid&&rsp_ready.
REQ-022 On an edge with rsp_valid=1 and rsp_ready=1, the block SHALL clear rsp_valid and enter IDLE; a new request is accepted no earlier than the following edge, giving a minimum of LAT+2 cycles per operation.
REQ-023 req_valid SHALL be ignored outside IDLE, and no request SHALL be lost or queued.
REQ-024 The block SHALL NOT inspect or modify result values; arithmetic is owned by the ALU.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 While reset=1 at an edge: state SHALL become IDLE; rsp_valid, busy, rsp_data, alu_a, alu_b, alu_func SHALL become 0; the counter SHALL become 0.
REQ-027 Reset SHALL take priority over every handshake on the same edge, including reset during EXEC or DONE, which abandons the operation with no rsp_valid pulse.
REQ-028 req_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-029 Macro ALU_CTRL_ACC_EN defined: the module SHALL add input req_acc (1 bit) and an n-bit accumulator register, reset to 0, loaded with each captured result; an accepted request with req_acc=1 SHALL launch the accumulator value on alu_a in place of req_a.
REQ-030 Macro ALU_CTRL_ACC_EN undefined: there SHALL be no req_acc port and no accumulator, and alu_a SHALL always come from req_a.

Verification
REQ-031 With LAT=1 and the ALU model, request ADD a=0x03 b=0x14 -> one cycle later alu_func=2'b10, alu_a=0x03, alu_b=0x14; next cycle rsp_valid=1 with rsp_data=0x17.
REQ-032 Request MUL a=0x60 (0.75) b=0x05 -> alu_func=2'b11 and rsp_data=0x03 (integer part of 3.75).
REQ-033 With LAT=3 -> rsp_valid rises exactly 3 edges after the launch edge, and alu_* outputs stay stable throughout.
REQ-034 Hold rsp_ready=0 for 5 cycles while req_valid=1 with new operands -> rsp_data is unchanged, req_ready=0, and the second request is accepted only after the response handshake.
REQ-035 Assert reset during EXEC -> next cycle all outputs are 0, no rsp_valid pulse occurs, and req_ready=1 after reset deasserts.
REQ-036 With ALU_CTRL_ACC_EN defined: ADD 0x03+0x14, then ADD with req_acc=1 and b=0x01 -> alu_a=0x17 and rsp_data=0x18.
